// File: rtl/timer_pkg.sv
// Shared types and defaults for the control-path timer blocks.
package timer_pkg;

  typedef enum logic [1:0] {
    WD_IDLE    = 2'd0,
    WD_ARMED   = 2'd1,
    WD_EXPIRED = 2'd2
  } wd_state_t;

  localparam int WD_CNT_W = 16;

endpackage

// File: rtl/tick_watchdog.sv
// Seconds watchdog: counts ticks while armed, kicked on progress, raises a
// sticky timeout once the programmed number of seconds has elapsed.
module tick_watchdog
  import timer_pkg::*;
#(
  parameter int CNT_W = WD_CNT_W
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             arm_i,
  input  logic             kick_i,
  input  logic             disarm_i,
  input  logic             ack_i,
  input  logic [CNT_W-1:0] timeout_sec_i,
  output logic             timeout_o,
  output logic             expire_pulse_o,
  output logic [CNT_W-1:0] elapsed_o,
  output logic [1:0]       state_o
);

  wd_state_t        state_q;
  logic [CNT_W-1:0] elapsed_q;
  logic [CNT_W-1:0] limit_q;
  logic             timeout_q;
  logic             pulse_q;

  // One extra bit so a limit of all-ones compares without overflow.
  logic [CNT_W:0] elapsed_d;
  assign elapsed_d = {1'b0, elapsed_q} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= WD_IDLE;
      elapsed_q <= '0;
      limit_q   <= '0;
      timeout_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (state_q == WD_EXPIRED) begin
        if (ack_i || disarm_i) begin
          state_q   <= WD_IDLE;
          elapsed_q <= '0;
          timeout_q <= 1'b0;
        end
      end else if (disarm_i) begin
        state_q   <= WD_IDLE;
        elapsed_q <= '0;
      end else if (arm_i) begin
        limit_q   <= timeout_sec_i;
        elapsed_q <= '0;
        if (timeout_sec_i == '0) begin
          state_q   <= WD_EXPIRED;
          timeout_q <= 1'b1;
          pulse_q   <= 1'b1;
        end else begin
          state_q <= WD_ARMED;
        end
      end else if (state_q == WD_ARMED) begin
        if (kick_i) begin
          elapsed_q <= '0;
        end else if (tick_i) begin
          elapsed_q <= elapsed_d[CNT_W-1:0];
          if (elapsed_d == {1'b0, limit_q}) begin
            state_q   <= WD_EXPIRED;
            timeout_q <= 1'b1;
            pulse_q   <= 1'b1;
          end
        end
      end else if (state_q != WD_IDLE) begin
        state_q <= WD_IDLE;
      end
    end
  end

  assign timeout_o      = timeout_q;
  assign expire_pulse_o = pulse_q;
  assign elapsed_o      = elapsed_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_tick_watchdog.sv
// Directed bench for tick_watchdog: a default-width and a 4-bit instance share
// stimulus and are checked every cycle against a seconds-level model.
module tb_tick_watchdog;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        tick_i = 1'b0, arm_i = 1'b0, kick_i = 1'b0, disarm_i = 1'b0, ack_i = 1'b0;
  logic [15:0] ts = '0;

  logic        to16, pu16, to4, pu4;
  logic [15:0] el16;
  logic [3:0]  el4;
  logic [1:0]  st16, st4;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  tick_watchdog u_dut (
    .clk(clk), .rst_i(rst_i), .tick_i(tick_i), .arm_i(arm_i), .kick_i(kick_i),
    .disarm_i(disarm_i), .ack_i(ack_i), .timeout_sec_i(ts),
    .timeout_o(to16), .expire_pulse_o(pu16), .elapsed_o(el16), .state_o(st16)
  );

  tick_watchdog #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_i(rst_i), .tick_i(tick_i), .arm_i(arm_i), .kick_i(kick_i),
    .disarm_i(disarm_i), .ack_i(ack_i), .timeout_sec_i(ts[3:0]),
    .timeout_o(to4), .expire_pulse_o(pu4), .elapsed_o(el4), .state_o(st4)
  );

  // Model: per instance, what the watchdog must show after each edge.
  // Modes: 0 idle, 1 watching, 2 expired. Index 0 = 16-bit, 1 = 4-bit.
  int m_mode[2], m_sec[2], m_lim[2], m_new[2];
  int m_mask[2] = '{32'hFFFF, 32'hF};

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      m_new[k] = 0;
      if (rst_i) begin
        m_mode[k] = 0; m_sec[k] = 0; m_lim[k] = 0;
      end else if (m_mode[k] == 2) begin
        if (ack_i || disarm_i) begin m_mode[k] = 0; m_sec[k] = 0; end
      end else if (disarm_i) begin
        m_mode[k] = 0; m_sec[k] = 0;
      end else if (arm_i) begin
        m_lim[k] = int'(ts) & m_mask[k];
        m_sec[k] = 0;
        m_mode[k] = (m_lim[k] == 0) ? 2 : 1;
        m_new[k] = (m_lim[k] == 0) ? 1 : 0;
      end else if (m_mode[k] == 1) begin
        if (kick_i) m_sec[k] = 0;
        else if (tick_i) begin
          m_sec[k] = m_sec[k] + 1;
          if (m_sec[k] == m_lim[k]) begin m_mode[k] = 2; m_new[k] = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if (int'(st16) != m_mode[0] || int'(el16) != m_sec[0] ||
          to16 != (m_mode[0] == 2) || int'(pu16) != m_new[0]) begin
        n_fail++;
        $display("FAIL model_w16 cyc=%0d got st=%0d el=%0d to=%0b pu=%0b exp st=%0d el=%0d to=%0b pu=%0d",
                 cyc, st16, el16, to16, pu16, m_mode[0], m_sec[0], m_mode[0] == 2, m_new[0]);
      end
      n_chk++;
      if (int'(st4) != m_mode[1] || int'(el4) != m_sec[1] ||
          to4 != (m_mode[1] == 2) || int'(pu4) != m_new[1]) begin
        n_fail++;
        $display("FAIL model_w4 cyc=%0d got st=%0d el=%0d to=%0b pu=%0b exp st=%0d el=%0d to=%0b pu=%0d",
                 cyc, st4, el4, to4, pu4, m_mode[1], m_sec[1], m_mode[1] == 2, m_new[1]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns just after the edge that consumed them.
  task automatic step(input bit a, input bit k, input bit t, input bit d, input bit c,
                      input logic [15:0] sec);
    arm_i = a; kick_i = k; tick_i = t; disarm_i = d; ack_i = c; ts = sec;
    @(posedge clk); #1;
    arm_i = 0; kick_i = 0; tick_i = 0; disarm_i = 0; ack_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, ts);
  endtask

  task automatic tick();
    step(0, 0, 1, 0, 0, ts);
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 0;
    chk_en = 1;
    chk("reset_state", st16, 0);
    chk("reset_elapsed", el16, 0);
    chk("reset_timeout", to16, 0);
    chk("reset_pulse", pu16, 0);

    // Ignored inputs in idle
    step(0, 1, 1, 0, 1, 16'd4);
    chk("idle_ignores", st16, 0);

    // Basic expiry, ticks 5 cycles apart
    step(1, 0, 0, 0, 0, 16'd3);
    chk("arm_state", st16, 1);
    tick(); chk("exp_el1", el16, 1);
    idle(4);
    tick(); chk("exp_el2", el16, 2);
    idle(4);
    tick();
    chk("exp_state", st16, 2);
    chk("exp_timeout", to16, 1);
    chk("exp_pulse", pu16, 1);
    chk("exp_el3", el16, 3);
    idle(1);
    chk("exp_pulse_once", pu16, 0);
    chk("exp_sticky", to16, 1);
    tick(); step(0, 1, 0, 0, 0, ts);
    chk("exp_frozen", el16, 3);
    step(0, 0, 0, 0, 1, ts);
    chk("ack_state", st16, 0);
    chk("ack_timeout", to16, 0);

    // Kick with simultaneous tick discards the tick
    step(1, 0, 0, 0, 0, 16'd3);
    tick(); tick();
    step(0, 1, 1, 0, 0, ts);
    chk("kick_el", el16, 0);
    tick(); tick();
    chk("kick_still_armed", st16, 1);
    tick();
    chk("kick_expired", st16, 2);
    step(0, 0, 0, 1, 0, ts);
    chk("disarm_from_exp", st16, 0);

    // Zero limit expires without a tick; arm ignored while expired
    step(1, 0, 0, 0, 0, 16'd0);
    chk("zero_state", st16, 2);
    chk("zero_pulse", pu16, 1);
    step(1, 0, 0, 0, 0, 16'd5);
    chk("exp_arm_ignored", st16, 2);
    chk("exp_arm_no_pulse", pu16, 0);
    step(0, 0, 0, 0, 1, ts);

    // disarm beats arm and tick
    step(1, 0, 0, 0, 0, 16'd5);
    tick();
    step(1, 0, 1, 1, 0, 16'd7);
    chk("prio_state", st16, 0);
    chk("prio_el", el16, 0);

    // Re-arm while armed restarts; limit input ignored until next arm
    step(1, 0, 0, 0, 0, 16'd4);
    tick();
    step(1, 0, 0, 0, 0, 16'd2);
    chk("rearm_el", el16, 0);
    ts = 16'd9;
    tick(); tick();
    chk("limit_latched", st16, 2);
    step(0, 0, 0, 0, 1, ts);

    // Max 4-bit limit, reset mid-count
    step(1, 0, 0, 0, 0, 16'd15);
    repeat (7) tick();
    chk("max_mid_el4", el4, 7);
    rst_i = 1; idle(1); rst_i = 0;
    chk("midrst_state", st4, 0);
    chk("midrst_el", el4, 0);
    step(1, 0, 0, 0, 0, 16'd15);
    repeat (14) tick();
    chk("max_armed4", st4, 1);
    tick();
    chk("max_el4", el4, 15);
    chk("max_state4", st4, 2);
    chk("max_pulse4", pu4, 1);
    chk("max_state16", st16, 2);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_bound bench did not complete in time");
    $fatal(1, "time limit");
  end

endmodule
